// File: rtl/rmt_cfg_pkg.sv
// Shared definitions for the RMT stage configuration path.
// Holds the table-target encodings, the sequencer state encodings,
// the default table widths and a small saturating-counter helper.
package rmt_cfg_pkg;

    // Default widths of the three stage tables
    localparam int KEY_OFF_DEF = 18;
    localparam int KEY_LEN_DEF = 197;
    localparam int ACT_W_DEF   = 625;
    localparam int ADDR_W_DEF  = 4;

    // Table-write target encodings carried on cfg_target
    localparam logic [1:0] CFG_TGT_KEYOFF = 2'd0;
    localparam logic [1:0] CFG_TGT_CAM    = 2'd1;
    localparam logic [1:0] CFG_TGT_ACT    = 2'd2;
    localparam logic [1:0] CFG_TGT_RSVD   = 2'd3;

    // Configuration sequencer states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HOLD     = 3'd1;
    localparam logic [2:0] ST_WRITE    = 3'd2;
    localparam logic [2:0] ST_CAM_WAIT = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        logic [15:0] res;
        if (val == 16'hFFFF) begin
            res = val;
        end else begin
            res = val + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/phv_inflight_cnt.sv
// Saturating up/down counter of PHVs currently inside the stage.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   inc       - a PHV enters the stage this cycle
//   dec       - a PHV leaves the stage this cycle
//   empty     - no PHV in flight (count == 0)
module phv_inflight_cnt #(
    parameter int W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic empty
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

    logic [W-1:0] count_r;

    // Count entries minus exits; simultaneous enter and exit cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else if (inc && !dec && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else if (dec && !inc && (count_r != CNT_ZERO)) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign empty = (count_r == CNT_ZERO);

endmodule

// File: rtl/stage_cfg_ctrl.sv
// Configuration sequencer for one RMT match-action stage.
// Accepts a table write, stalls upstream and drains in-flight PHVs,
// issues one single-cycle write to the key-offset RAM, lookup CAM or
// action RAM, waits for the CAM to finish, then answers done or error.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   cfg_*                    - command channel (valid/ready) and response pulses
//   phv_in_valid/out_valid   - PHVs entering/leaving the stage
//   phv_hold                 - upstream stall request
//   key_off_entry_*          - key-offset RAM write channel
//   lookup_din*, cam_busy    - CAM write channel and its busy flag
//   action_*                 - action RAM write channel
// Optional build macro STAGE_CFG_STATS_EN adds cfg_wr_cnt / cfg_drop_cnt
// (saturating counts of completed writes and of drops plus errors).
module stage_cfg_ctrl
    import rmt_cfg_pkg::*;
#(
    parameter int STAGE   = 0,
    parameter int KEY_OFF = KEY_OFF_DEF,
    parameter int KEY_LEN = KEY_LEN_DEF,
    parameter int ACT_W   = ACT_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INFL_W  = 4,
    parameter int CAM_TMO = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_stage,
    input  logic [1:0]         cfg_target,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [ACT_W-1:0]   cfg_data,
    input  logic [KEY_LEN-1:0] cfg_mask,
    output logic               cfg_done,
    output logic               cfg_err,
    input  logic               phv_in_valid,
    input  logic               phv_out_valid,
    output logic               phv_hold,
    output logic [KEY_OFF-1:0] key_off_entry_in,
    output logic               key_off_entry_in_valid,
    output logic [ADDR_W-1:0]  key_off_entry_addr,
    output logic [KEY_LEN-1:0] lookup_din,
    output logic [KEY_LEN-1:0] lookup_din_mask,
    output logic [ADDR_W-1:0]  lookup_din_addr,
    output logic               lookup_din_en,
    input  logic               cam_busy,
    output logic [ACT_W-1:0]   action_data_in,
    output logic               action_en,
    output logic [ADDR_W-1:0]  action_addr
`ifdef STAGE_CFG_STATS_EN
    ,
    output logic [15:0]        cfg_wr_cnt,
    output logic [15:0]        cfg_drop_cnt
`endif
);

    localparam int TMO_W = $clog2(CAM_TMO + 1);
    // Last count value still inside the wait window; reaching it ends the wait
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CAM_TMO - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [2:0]         state_r;
    logic [2:0]         state_nxt_s;
    logic               accept_s;
    logic               stage_ok_s;
    logic               err_set_s;
    logic               empty_s;
    logic [1:0]         cmd_tgt_r;
    logic [ADDR_W-1:0]  cmd_addr_r;
    logic [ACT_W-1:0]   cmd_data_r;
    logic [KEY_LEN-1:0] cmd_mask_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               cfg_ready_r;
    logic               phv_hold_r;
    logic               koff_wr_r;
    logic               cam_wr_r;
    logic               act_wr_r;
    logic               cfg_done_r;
    logic               cfg_err_r;

    assign accept_s   = cfg_valid & cfg_ready_r;
    assign stage_ok_s = (cfg_stage == 3'(STAGE));

    phv_inflight_cnt #(
        .W (INFL_W)
    ) u_inflight (
        .clk   (clk),
        .rst   (rst),
        .inc   (phv_in_valid),
        .dec   (phv_out_valid),
        .empty (empty_s)
    );

    // Next-state decode; err_set_s flags a reserved target or a CAM timeout
    always_comb begin
        state_nxt_s = state_r;
        err_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && stage_ok_s) begin
                    if (cfg_target == CFG_TGT_RSVD) begin
                        err_set_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A PHV arriving this cycle would still be in flight at the write
                if (empty_s && !phv_in_valid) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_WRITE: begin
                if (cmd_tgt_r == CFG_TGT_CAM) begin
                    state_nxt_s = ST_CAM_WAIT;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_CAM_WAIT: begin
                if (!cam_busy) begin
                    state_nxt_s = ST_RESP;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_nxt_s = ST_IDLE;
                    err_set_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_CAM_WAIT;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and control outputs, registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cfg_ready_r <= 1'b1;
            phv_hold_r  <= 1'b0;
            koff_wr_r   <= 1'b0;
            cam_wr_r    <= 1'b0;
            act_wr_r    <= 1'b0;
            cfg_done_r  <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cfg_ready_r <= (state_nxt_s == ST_IDLE);
            phv_hold_r  <= (state_nxt_s == ST_HOLD) || (state_nxt_s == ST_WRITE) ||
                           (state_nxt_s == ST_CAM_WAIT);
            koff_wr_r   <= (state_nxt_s == ST_WRITE) && (cmd_tgt_r == CFG_TGT_KEYOFF);
            cam_wr_r    <= (state_nxt_s == ST_WRITE) && (cmd_tgt_r == CFG_TGT_CAM);
            act_wr_r    <= (state_nxt_s == ST_WRITE) && (cmd_tgt_r == CFG_TGT_ACT);
            cfg_done_r  <= (state_nxt_s == ST_RESP);
            cfg_err_r   <= err_set_s;
        end
    end

    // Command register: captured on every accepted command
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_tgt_r  <= 2'd0;
            cmd_addr_r <= {ADDR_W{1'b0}};
            cmd_data_r <= {ACT_W{1'b0}};
            cmd_mask_r <= {KEY_LEN{1'b0}};
        end else if (accept_s) begin
            cmd_tgt_r  <= cfg_target;
            cmd_addr_r <= cfg_addr;
            cmd_data_r <= cfg_data;
            cmd_mask_r <= cfg_mask;
        end else begin
            cmd_tgt_r  <= cmd_tgt_r;
            cmd_addr_r <= cmd_addr_r;
            cmd_data_r <= cmd_data_r;
            cmd_mask_r <= cmd_mask_r;
        end
    end

    // CAM wait timer: runs only while waiting, cleared otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == ST_CAM_WAIT) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

`ifdef STAGE_CFG_STATS_EN
    logic [15:0] wr_cnt_r;
    logic [15:0] drop_cnt_r;

    // Saturating statistics: completed writes, and wrong-stage drops plus errors
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r   <= 16'd0;
            drop_cnt_r <= 16'd0;
        end else begin
            if (state_nxt_s == ST_RESP) begin
                wr_cnt_r <= sat_inc16(wr_cnt_r);
            end else begin
                wr_cnt_r <= wr_cnt_r;
            end
            if ((accept_s && !stage_ok_s) || err_set_s) begin
                drop_cnt_r <= sat_inc16(drop_cnt_r);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign cfg_wr_cnt   = wr_cnt_r;
    assign cfg_drop_cnt = drop_cnt_r;
`endif

    assign cfg_ready              = cfg_ready_r;
    assign cfg_done               = cfg_done_r;
    assign cfg_err                = cfg_err_r;
    assign phv_hold               = phv_hold_r;
    assign key_off_entry_in       = cmd_data_r[KEY_OFF-1:0];
    assign key_off_entry_in_valid = koff_wr_r;
    assign key_off_entry_addr     = cmd_addr_r;
    assign lookup_din             = cmd_data_r[KEY_LEN-1:0];
    assign lookup_din_mask        = cmd_mask_r;
    assign lookup_din_addr        = cmd_addr_r;
    assign lookup_din_en          = cam_wr_r;
    assign action_data_in         = cmd_data_r;
    assign action_en              = act_wr_r;
    assign action_addr            = cmd_addr_r;

endmodule
